// File: rtl/pipe_pkg.sv
// pipe_pkg: shared constants, entry header and occupancy state encoding for pipeline stage registers
package pipe_pkg;

    localparam int EXC_NONE = 0;
    localparam logic [31:0] HANDLER_PC_DEFAULT = 32'h0000_4180;

    // Encoding doubles as the held-entry count
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        MAIN  = 2'd1,
        BOTH  = 2'd2
    } state_e;

    // Fixed-width part of every entry; payload and exception code are sized per instance
    typedef struct packed {
        logic [31:0] pc;
        logic        bd;
    } entry_hdr_t;

endpackage

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline register with flush and exception redirect; PIPE_STAGE_SKID_EN adds a skid entry and registered in_ready
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int          PAYLOAD_W  = 32,
    parameter int          EXC_W      = 5,
    parameter logic [31:0] HANDLER_PC = HANDLER_PC_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_pc,
    input  logic [PAYLOAD_W-1:0] in_payload,
    input  logic                 in_bd,
    input  logic [EXC_W-1:0]     in_exccode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_pc,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic                 out_bd,
    output logic [EXC_W-1:0]     out_exccode,
    input  logic                 flush,
    input  logic                 req,
    output logic [1:0]           occupancy
);

    typedef struct packed {
        entry_hdr_t           hdr;
        logic [PAYLOAD_W-1:0] payload;
        logic [EXC_W-1:0]     exccode;
    } entry_t;

    localparam entry_t HANDLER_ENTRY = '{
        hdr:     '{pc: HANDLER_PC, bd: 1'b0},
        payload: '0,
        exccode: EXC_W'(EXC_NONE)
    };

    state_e state_q, state_d;
    entry_t main_q, main_d, in_entry;
    logic   in_fire, out_fire;

    assign in_entry = '{
        hdr:     '{pc: in_pc, bd: in_bd},
        payload: in_payload,
        exccode: in_exccode
    };

    assign out_valid   = state_q != EMPTY;
    assign out_fire    = out_valid & out_ready;
    assign in_fire     = in_valid & in_ready;
    assign occupancy   = state_q;
    assign out_pc      = main_q.hdr.pc;
    assign out_bd      = main_q.hdr.bd;
    assign out_payload = main_q.payload;
    assign out_exccode = main_q.exccode;

`ifdef PIPE_STAGE_SKID_EN
    entry_t skid_q, skid_d;
    logic   in_ready_q;

    assign in_ready = in_ready_q;
`else
    // Single entry: accept whenever the held entry is absent or leaving this cycle
    assign in_ready = !out_valid | out_ready;
`endif

    // Next-state: req beats flush beats handshake; a killed cycle discards any input transfer
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
`ifdef PIPE_STAGE_SKID_EN
        skid_d  = skid_q;
`endif
        if (req) begin
            state_d = EMPTY;
            main_d  = HANDLER_ENTRY;
        end else if (flush) begin
            state_d = EMPTY;
            main_d  = '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        main_d  = in_entry;
                        state_d = MAIN;
                    end
                end
                MAIN: begin
                    if (in_fire && out_fire) begin
                        main_d = in_entry;
`ifdef PIPE_STAGE_SKID_EN
                    end else if (in_fire) begin
                        skid_d  = in_entry;
                        state_d = BOTH;
`endif
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
`ifdef PIPE_STAGE_SKID_EN
                BOTH: begin
                    if (out_fire) begin
                        main_d  = skid_q;
                        state_d = MAIN;
                    end
                end
`endif
                default: state_d = EMPTY;
            endcase
        end
    end

`ifdef PIPE_STAGE_SKID_EN
    // State and storage; in_ready is registered from the next state so it never combines with out_ready
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= state_d != BOTH;
        end
    end
`else
    // State and storage for the single-entry build
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= EMPTY;
            main_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed and random scoreboard test of pipe_stage_reg (either PIPE_STAGE_SKID_EN build)
module tb_pipe_stage_reg;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] payload;
        logic        bd;
        logic [4:0]  exc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_pc = '0;
    logic [31:0] in_payload = '0;
    logic        in_bd = 1'b0;
    logic [4:0]  in_exccode = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [31:0] out_payload;
    logic        out_bd;
    logic [4:0]  out_exccode;
    logic        flush = 1'b0;
    logic        req = 1'b0;
    logic [1:0]  occupancy;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail = 0;
`ifdef PIPE_STAGE_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    pipe_stage_reg dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_payload(in_payload),
        .in_bd(in_bd), .in_exccode(in_exccode),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_payload(out_payload),
        .out_bd(out_bd), .out_exccode(out_exccode),
        .flush(flush), .req(req), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] pl,
                         input logic bd, input logic [4:0] exc);
        in_valid = v; in_pc = pc; in_payload = pl; in_bd = bd; in_exccode = exc;
    endtask

    // Checks handshake state against the model at the negedge, scores any output transfer, then advances one cycle
    task automatic step();
        logic exp_rdy;
        exp_t e, o;
        @(negedge clk);
`ifdef PIPE_STAGE_SKID_EN
        exp_rdy = q.size() < 2;
`else
        exp_rdy = (q.size() == 0) || out_ready;
`endif
        chk("in_ready", 64'(in_ready), 64'(exp_rdy));
        chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
        chk("occupancy", 64'(occupancy), 64'(q.size()));
        if (q.size() != 0 && out_ready) begin
            o = q.pop_front();
            chk("out_pc", 64'(out_pc), 64'(o.pc));
            chk("out_payload", 64'(out_payload), 64'(o.payload));
            chk("out_bd", 64'(out_bd), 64'(o.bd));
            chk("out_exccode", 64'(out_exccode), 64'(o.exc));
        end
        if (req || flush) q.delete();
        else if (in_valid && exp_rdy) begin
            e.pc = in_pc; e.payload = in_payload; e.bd = in_bd; e.exc = in_exccode;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag, input logic [31:0] pc);
        chk({tag, "_pc"}, 64'(out_pc), 64'(pc));
        chk({tag, "_payload"}, 64'(out_payload), 64'h0);
        chk({tag, "_bd"}, 64'(out_bd), 64'h0);
        chk({tag, "_exc"}, 64'(out_exccode), 64'h0);
        chk({tag, "_valid"}, 64'(out_valid), 64'h0);
        chk({tag, "_occ"}, 64'(occupancy), 64'h0);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'h1);
    endtask

    initial begin
        // Reset values while held in reset
        #13;
        check_idle("reset", 32'h0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // First transfer into EMPTY appears one cycle later
        out_ready = 1'b1;
        drive(1'b1, 32'h3000, 32'h2401_0005, 1'b0, 5'd0);
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 5'd0);
        chk("first_pc", 64'(out_pc), 64'h3000);
        chk("first_occ", 64'(occupancy), 64'h1);
        step();

        // Back-to-back stream at full throughput
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 32'h3100 + 32'(4 * i), $urandom, 1'(i), 5'(i));
            step();
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 5'd0);
        step();

        // Stall with a branch-delay entry carrying an exception code
        drive(1'b1, 32'h3200, 32'hdead_beef, 1'b1, 5'd4);
        step();
        out_ready = 1'b0;
        drive(1'b1, 32'h3204, 32'h1234_5678, 1'b0, 5'd0);
`ifdef PIPE_STAGE_SKID_EN
        in_valid = 1'b0;
`endif
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_bd", 64'(out_bd), 64'h1);
            chk("stall_exc", 64'(out_exccode), 64'h4);
            chk("stall_pc", 64'(out_pc), 64'h3200);
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 5'd0);
        out_ready = 1'b1;
        step();
        step();

`ifdef PIPE_STAGE_SKID_EN
        // Skid fill: second entry lands in the skid, then both emerge in order
        drive(1'b1, 32'h3000, 32'h2401_0005, 1'b0, 5'd0);
        step();
        out_ready = 1'b0;
        drive(1'b1, 32'h3004, 32'h2402_0006, 1'b0, 5'd0);
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 5'd0);
        chk("skid_occ", 64'(occupancy), 64'h2);
        chk("skid_in_ready", 64'(in_ready), 64'h0);
        out_ready = 1'b1;
        step();
        step();
        step();
`endif

        // req while holding entries and offering input: handler bubble
        out_ready = 1'b0;
        drive(1'b1, 32'h3300, 32'h1111_1111, 1'b1, 5'd2);
        step();
        drive(1'b1, 32'h3304, 32'h2222_2222, 1'b0, 5'd3);
        step();
        req = 1'b1;
        drive(1'b1, 32'h3308, 32'h3333_3333, 1'b1, 5'd1);
        step();
        req = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 5'd0);
        check_idle("req", 32'h0000_4180);

        // flush kills the held entry and zeroes the output
        drive(1'b1, 32'h3400, 32'h4444_4444, 1'b1, 5'd6);
        step();
        flush = 1'b1;
        drive(1'b1, 32'h3404, 32'h5555_5555, 1'b0, 5'd0);
        step();
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 5'd0);
        check_idle("flush", 32'h0);

        // req and flush together: req wins
        drive(1'b1, 32'h3500, 32'h6666_6666, 1'b0, 5'd0);
        step();
        flush = 1'b1;
        req = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 5'd0);
        step();
        flush = 1'b0;
        req = 1'b0;
        check_idle("req_flush", 32'h0000_4180);

        // Asynchronous reset mid-transfer with out_valid high
        drive(1'b1, 32'h3600, 32'h7777_7777, 1'b1, 5'd7);
        step();
        chk("pre_reset_valid", 64'(out_valid), 64'h1);
        reset = 1'b0;
        #1;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 5'd0);
        q.delete();
        check_idle("async_reset", 32'h0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Random traffic
        for (int i = 0; i < 60; i++) begin
            drive(1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom), 5'($urandom));
            out_ready = 1'($urandom_range(0, 3) != 0);
            step();
        end

        // Drain within a bounded number of cycles
        drive(1'b0, 32'h0, 32'h0, 1'b0, 5'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 4 * CAP && q.size() != 0; i++) step();
        chk("drain_left", 64'(q.size()), 64'h0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised inter-stage pipeline register for the five-stage MIPS core. It generalises the fixed F→D latch into one block that every stage boundary instantiates. It carries PC, payload, branch-delay flag and pending exception code under a valid/ready handshake. It supports flush (kill) and exception request (redirect to handler PC), and has an optional two-entry skid buffer that breaks the combinational ready path.

## Interface
Parameters:
- PAYLOAD_W, 32, width of stage payload (instruction word or packed control bundle)
- EXC_W, 5, exception-code width
- HANDLER_PC, 32'h0000_4180, PC loaded into the output entry on `req`

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low; `reset`=0 clears all state immediately
- in_valid  in  1  upstream entry present
- in_ready  out  1  stage can accept; a transfer occurs when in_valid & in_ready
- in_pc  in  32  upstream PC
- in_payload  in  PAYLOAD_W  upstream payload
- in_bd  in  1  upstream branch-delay-slot flag
- in_exccode  in  EXC_W  upstream pending exception code (0 = none)
- out_valid  out  1  output entry present
- out_ready  in  1  downstream accepts; a transfer occurs when out_valid & out_ready
- out_pc / out_payload / out_bd / out_exccode  out  32/PAYLOAD_W/1/EXC_W  registered output entry
- flush  in  1  kill all held entries
- req  in  1  exception request from CP0; kill all entries and load handler bubble
- occupancy  out  2  number of held entries, 0..2

## Operation
- Entry = {pc, payload, bd, exccode}. Main entry drives out_*. Skid entry is used only with the macro.
- Priority per edge: reset > req > flush > handshake.
- req: main ← {HANDLER_PC, 0, 0, 0}, out_valid=0, skid invalidated, occupancy=0. Any same-cycle input transfer is discarded.
- flush: main ← all-zero, out_valid=0, skid invalidated, occupancy=0. Same-cycle input is discarded.
- States (with skid): EMPTY (occ 0), MAIN (occ 1), BOTH (occ 2).
  - EMPTY: in fire → MAIN.
  - MAIN: in & out fire → MAIN (main replaced). In fire only → BOTH (input into skid). Out fire only → EMPTY.
  - BOTH: in_ready=0. Out fire → MAIN, main ← skid.
- Without skid: states EMPTY/MAIN only. in_ready = !out_valid | out_ready (combinational).
- Payload is never modified; exccode passes through unchanged. Earliest-stage exception stays with its entry.
- out_* hold their value while out_valid & !out_ready (stall). Stall never loses or duplicates an entry.

## Timing
- Reset values: out_valid 0, out_pc 0, out_payload 0, out_bd 0, out_exccode 0, occupancy 0, in_ready 1.
- Latency in→out: 1 cycle from an accepted transfer into EMPTY.
- With skid, in_ready is a flop output: in_ready = (state != BOTH), valid the cycle after the transition.
- req/flush take effect at the edge where they are sampled high. in_ready is 1 the following cycle.
- Reset asserted mid-transfer: entries are lost, outputs go to reset values asynchronously. Release is synchronised externally.
- Back-to-back throughput: 1 entry/cycle while out_ready=1, in both configurations.

## Configuration
- PIPE_STAGE_SKID_EN defined: two-entry skid buffer, registered in_ready, occupancy reaches 2.
- Not defined: single entry, combinational in_ready, occupancy ≤ 1, no skid flops synthesised.

## Structure
- Shared package pipe_pkg: EXC_NONE (0), HANDLER_PC default, entry struct typedef, state enum {EMPTY, MAIN, BOTH}.
- No sub-module. Both storage entries use the package struct inside this module.

## Test plan
- Reset low with out_valid=1 → all outputs at reset values within the same cycle; in_ready=1.
- in pc=0x3000, payload=0x2401_0005, out_ready=1 → next cycle out_valid=1, out_pc=0x3000, occupancy=1.
- Skid build: MAIN full, out_ready=0, in pc=0x3004 → occupancy=2, in_ready=0. out_ready=1 → pc 0x3000 then 0x3004 emitted in order.
- req while occupancy=2 and in_valid=1 → next cycle out_pc=0x0000_4180, out_payload=0, out_valid=0, occupancy=0, in_ready=1.
- flush and req same cycle → req wins: out_pc=0x0000_4180.
- Stall 5 cycles with in bd=1, exccode=4 → out_bd=1, out_exccode=4 held stable all 5 cycles; single transfer on release.
